// File: rtl/pdp8_tt_buffered_if.sv
// Bus bundle between the PDP-8 CPU IOT port, the UART side and the buffered TTY device.
interface pdp8_tt_buffered_if;
  logic        iot;
  logic [3:0]  state;
  logic [11:0] mb;
  logic [5:0]  io_select;
  logic [11:0] io_data_in;
  logic [11:0] io_data_out;
  logic        io_selected;
  logic        io_skip;
  logic        io_interrupt;
  logic        io_data_avail;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        rx_overrun;
  logic        tx_overrun;

  modport slave (
    input  iot, state, mb, io_select, io_data_in, rx_valid, rx_byte, tx_ready,
    output io_data_out, io_selected, io_skip, io_interrupt, io_data_avail,
           tx_valid, tx_byte, rx_overrun, tx_overrun
  );

  modport master (
    output iot, state, mb, io_select, io_data_in, rx_valid, rx_byte, tx_ready,
    input  io_data_out, io_selected, io_skip, io_interrupt, io_data_avail,
           tx_valid, tx_byte, rx_overrun, tx_overrun
  );
endinterface

// File: rtl/pdp8_tt_buffered.sv
// PDP-8 console TTY (keyboard + printer IOTs) with receive and transmit FIFOs toward a byte UART.
module pdp8_tt_buffered #(
  parameter logic [5:0]  DEV_IN  = 6'o03,
  parameter logic [5:0]  DEV_OUT = 6'o04,
  parameter int unsigned RX_AW   = 4,
  parameter int unsigned TX_AW   = 2,
  parameter bit          MARK8   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  pdp8_tt_buffered_if.slave    bus
);
  localparam int unsigned RX_DEPTH = 1 << RX_AW;
  localparam int unsigned TX_DEPTH = 1 << TX_AW;
  localparam int unsigned RX_CW    = RX_AW + 1;
  localparam int unsigned TX_CW    = TX_AW + 1;
  localparam logic [3:0]  ST_F1    = 4'b0001;
  localparam logic [7:0]  MARK_BIT = MARK8 ? 8'h80 : 8'h00;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_rd, rx_wr;
  logic [RX_AW:0]   rx_cnt;
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_rd, tx_wr;
  logic [TX_AW:0]   tx_cnt;
  logic             tx_flag, int_en, rx_ovr, tx_ovr;

  logic hit_in, hit_out, sel, sel_in, sel_out, kie, rx_fn;
  logic rx_flag, rx_full, rx_pop, rx_push, rx_drop;
  logic tx_full, tx_nempty, tx_pop, tx_push_req, tx_push;
  logic [7:0]  rd_byte;
  logic [11:0] data_out;
  logic        skip;

  // IOT decode; keyboard wins if both device codes are configured equal
  assign hit_in  = bus.io_select == DEV_IN;
  assign hit_out = bus.io_select == DEV_OUT;
  assign sel     = bus.iot && (bus.state == ST_F1) && (hit_in || hit_out);
  assign sel_in  = sel && hit_in;
  assign sel_out = sel && hit_out && !hit_in;
  assign kie     = sel_in && (bus.mb[2:0] == 3'b101);
  assign rx_fn   = sel_in && !kie;

  assign rx_flag = rx_cnt != '0;
  assign rx_full = rx_cnt == RX_CW'(RX_DEPTH);
  assign rx_pop  = rx_fn && bus.mb[1] && rx_flag;
  // a full RX FIFO still accepts a byte when the head leaves on the same edge
  assign rx_push = bus.rx_valid && (!rx_full || rx_pop);
  assign rx_drop = bus.rx_valid && rx_full && !rx_pop;
  assign rd_byte = (rx_flag ? rx_mem[rx_rd] : 8'h00) | MARK_BIT;

  assign tx_nempty   = tx_cnt != '0;
  assign tx_full     = tx_cnt == TX_CW'(TX_DEPTH);
  assign tx_pop      = tx_nempty && bus.tx_ready;
  assign tx_push_req = sel_out && bus.mb[2];
  assign tx_push     = tx_push_req && !tx_full;

  always_comb begin
    data_out = bus.io_data_in;
    skip     = 1'b0;
    if (rx_fn) begin
      data_out = bus.mb[2] ? {4'b0000, rd_byte} : 12'o0000;
      skip     = bus.mb[0] && rx_flag;
    end else if (sel_out) begin
      skip     = bus.mb[0] && tx_flag;
    end
  end

  assign bus.io_data_out   = data_out;
  assign bus.io_skip       = skip;
  assign bus.io_selected   = sel;
  assign bus.io_interrupt  = int_en && (rx_flag || tx_flag);
  assign bus.io_data_avail = 1'b1;
  assign bus.tx_valid      = tx_nempty;
  assign bus.tx_byte       = tx_mem[tx_rd];
  assign bus.rx_overrun    = rx_ovr;
  assign bus.tx_overrun    = tx_ovr;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= bus.rx_byte;
    if (tx_push) tx_mem[tx_wr] <= bus.io_data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_rd   <= '0;
      rx_wr   <= '0;
      rx_cnt  <= '0;
      tx_rd   <= '0;
      tx_wr   <= '0;
      tx_cnt  <= '0;
      tx_flag <= 1'b0;
      int_en  <= 1'b1;
      rx_ovr  <= 1'b0;
      tx_ovr  <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + RX_CW'(1);
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - RX_CW'(1);

      if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TX_AW'(1);
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + TX_CW'(1);
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - TX_CW'(1);

      // a completed UART handshake outranks an IOT clearing the printer flag
      if (tx_pop)                                     tx_flag <= 1'b1;
      else if (sel_out && (bus.mb[1] || bus.mb[2]))   tx_flag <= 1'b0;

      if (kie) int_en <= bus.io_data_in[0];

      if (rx_drop)                     rx_ovr <= 1'b1;
      else if (rx_fn && bus.mb[1])     rx_ovr <= 1'b0;

      if (tx_push_req && tx_full) tx_ovr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pdp8_tt_buffered.sv
// Scoreboard bench: shallow-FIFO unit (a) for the IOT/FIFO behaviour, MARK8 unit (b) for forced bit 7.
module tb_pdp8_tt_buffered;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pdp8_tt_buffered_if a ();
  pdp8_tt_buffered_if b ();

  pdp8_tt_buffered #(.DEV_IN(6'o03), .DEV_OUT(6'o04), .RX_AW(1), .TX_AW(1), .MARK8(1'b0))
    dut (.clk(clk), .reset(reset), .bus(a.slave));
  pdp8_tt_buffered #(.DEV_IN(6'o03), .DEV_OUT(6'o04), .RX_AW(4), .TX_AW(2), .MARK8(1'b1))
    dut_m (.clk(clk), .reset(reset), .bus(b.slave));

  typedef struct { string name; logic [12:0] exp; } iot_e_t;
  typedef struct { string name; logic [3:0] flags; logic [7:0] txb; } st_e_t;

  iot_e_t     iota_q[$];
  iot_e_t     iotb_q[$];
  st_e_t      st_q[$];
  logic [7:0] tx_q[$];
  logic       probe_on = 1'b0;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_unexpected(input string name);
    n_checks++;
    $display("FAIL %s: DUT event with no queued expectation", name);
  endtask

  // unit a monitor: IOT responses, status probes, UART handshakes
  always @(negedge clk) begin
    iot_e_t ie;
    st_e_t  se;
    logic [7:0] tb;
    if (a.io_selected) begin
      if (iota_q.size() == 0) fail_unexpected("iot_a");
      else begin
        ie = iota_q.pop_front();
        check(ie.name, 32'({a.io_skip, a.io_data_out}), 32'(ie.exp));
      end
    end
    if (probe_on) begin
      if (st_q.size() == 0) fail_unexpected("probe");
      else begin
        se = st_q.pop_front();
        check(se.name,
              32'({a.rx_overrun, a.tx_overrun, a.io_interrupt, a.tx_valid,
                   (a.tx_valid ? a.tx_byte : 8'h00), a.io_selected, a.io_skip,
                   a.io_data_avail, a.io_data_out}),
              32'({se.flags, se.txb, 1'b0, 1'b0, 1'b1, 12'o5252}));
      end
    end
    if (!reset && a.tx_valid && a.tx_ready) begin
      if (tx_q.size() == 0) fail_unexpected("tx_byte");
      else begin
        tb = tx_q.pop_front();
        check("tx_byte", 32'(a.tx_byte), 32'(tb));
      end
    end
  end

  always @(negedge clk) begin
    iot_e_t ie;
    if (b.io_selected) begin
      if (iotb_q.size() == 0) fail_unexpected("iot_b");
      else begin
        ie = iotb_q.pop_front();
        check(ie.name, 32'({b.io_skip, b.io_data_out}), 32'(ie.exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input int u, input logic iot, input logic [3:0] st, input logic [11:0] mb,
                         input logic [11:0] ac, input logic rxv, input logic [7:0] rxb);
    if (u == 0) begin
      a.iot = iot; a.state = st; a.mb = mb; a.io_select = mb[8:3];
      a.io_data_in = ac; a.rx_valid = rxv; a.rx_byte = rxb;
    end else begin
      b.iot = iot; b.state = st; b.mb = mb; b.io_select = mb[8:3];
      b.io_data_in = ac; b.rx_valid = rxv; b.rx_byte = rxb;
    end
  endtask

  task automatic idle(input int u);
    set_bus(u, 1'b0, 4'b0000, 12'o0000, 12'o0000, 1'b0, 8'h00);
  endtask

  task automatic iot(input int u, input string name, input logic [11:0] mb, input logic [11:0] ac,
                     input logic exp_skip, input logic [11:0] exp_out,
                     input logic rxv = 1'b0, input logic [7:0] rxb = 8'h00, input logic txq = 1'b0);
    iot_e_t e;
    e.name = name;
    e.exp  = {exp_skip, exp_out};
    if (u == 0) iota_q.push_back(e);
    else        iotb_q.push_back(e);
    if (txq) tx_q.push_back(ac[7:0]);
    set_bus(u, 1'b1, 4'b0001, mb, ac, rxv, rxb);
    step();
    idle(u);
  endtask

  task automatic rx(input int u, input logic [7:0] v);
    set_bus(u, 1'b0, 4'b0000, 12'o0000, 12'o0000, 1'b1, v);
    step();
    idle(u);
  endtask

  // decode-miss IOT (device 05) while the status outputs are sampled
  task automatic probe(input string name, input logic [3:0] flags, input logic [7:0] txb);
    st_e_t e;
    e.name = name; e.flags = flags; e.txb = txb;
    st_q.push_back(e);
    set_bus(0, 1'b1, 4'b0001, 12'o6056, 12'o5252, 1'b0, 8'h00);
    probe_on = 1'b1;
    step();
    probe_on = 1'b0;
    idle(0);
  endtask

  task automatic tx_pulse(input int cycles);
    a.tx_ready = 1'b1;
    repeat (cycles) step();
    a.tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle(0); idle(1);
    a.tx_ready = 1'b0; b.tx_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    // flags order: rx_overrun, tx_overrun, io_interrupt, tx_valid
    probe("reset_state", 4'b0000, 8'h00);

    // receive order, non-F1 IOT must not pop
    rx(0, 8'o101); rx(0, 8'o102);
    set_bus(0, 1'b1, 4'b0010, 12'o6036, 12'o0000, 1'b0, 8'h00); step(); idle(0);
    probe("rx_two_queued", 4'b0010, 8'h00);
    iot(0, "ksf_1", 12'o6031, 12'o7777, 1'b1, 12'o0000);
    iot(0, "krb_1", 12'o6036, 12'o7777, 1'b0, 12'o0101);
    iot(0, "ksf_2", 12'o6031, 12'o7777, 1'b1, 12'o0000);
    iot(0, "krb_2", 12'o6036, 12'o7777, 1'b0, 12'o0102);
    iot(0, "ksf_3", 12'o6031, 12'o7777, 1'b0, 12'o0000);
    iot(0, "krb_empty", 12'o6036, 12'o7777, 1'b0, 12'o0000);
    probe("rx_drained", 4'b0000, 8'h00);

    // receive overflow on a depth-2 FIFO
    rx(0, 8'h11); rx(0, 8'h22); rx(0, 8'h33);
    probe("rx_overrun_set", 4'b1010, 8'h00);
    iot(0, "krb_ovf_1", 12'o6036, 12'o0000, 1'b0, 12'h011);
    probe("rx_overrun_clr", 4'b0010, 8'h00);
    iot(0, "krb_ovf_2", 12'o6036, 12'o0000, 1'b0, 12'h022);
    iot(0, "ksf_ovf", 12'o6031, 12'o0000, 1'b0, 12'o0000);

    // full FIFO with a pop on the same edge accepts the new byte
    rx(0, 8'h44); rx(0, 8'h55);
    iot(0, "krb_full_pop", 12'o6036, 12'o0000, 1'b0, 12'h044, 1'b1, 8'h66);
    iot(0, "krb_full_2", 12'o6036, 12'o0000, 1'b0, 12'h055);
    iot(0, "krb_full_3", 12'o6036, 12'o0000, 1'b0, 12'h066);
    probe("full_pop_no_ovr", 4'b0000, 8'h00);

    // interrupt enable
    iot(0, "kie_off", 12'o6035, 12'o0000, 1'b0, 12'o0000);
    rx(0, 8'h41);
    probe("kie_irq_masked", 4'b0000, 8'h00);
    iot(0, "ksf_kie", 12'o6031, 12'o0000, 1'b1, 12'o0000);
    iot(0, "kie_on", 12'o6035, 12'o0001, 1'b0, 12'o0001);
    probe("kie_irq_on", 4'b0010, 8'h00);
    iot(0, "krb_kie", 12'o6036, 12'o0000, 1'b0, 12'h041);
    probe("kie_drained", 4'b0000, 8'h00);

    // transmit flow
    iot(0, "tls_141", 12'o6046, 12'o0141, 1'b0, 12'o0141, 1'b0, 8'h00, 1'b1);
    probe("tx_pending", 4'b0001, 8'h61);
    tx_pulse(1);
    probe("tx_done_flag", 4'b0010, 8'h00);
    iot(0, "tsf_set", 12'o6041, 12'o0141, 1'b1, 12'o0141);
    iot(0, "tcf", 12'o6042, 12'o0000, 1'b0, 12'o0000);
    probe("tx_flag_clr", 4'b0000, 8'h00);

    // transmit FIFO full: third byte dropped
    iot(0, "tls_a1", 12'o6046, 12'h0a1, 1'b0, 12'h0a1, 1'b0, 8'h00, 1'b1);
    iot(0, "tls_a2", 12'o6046, 12'h0a2, 1'b0, 12'h0a2, 1'b0, 8'h00, 1'b1);
    iot(0, "tls_a3", 12'o6046, 12'h0a3, 1'b0, 12'h0a3);
    probe("tx_overrun_set", 4'b0101, 8'ha1);
    tx_pulse(3);
    probe("tx_full_drained", 4'b0110, 8'h00);

    // push and handshake pop on the same edge
    iot(0, "tls_b1", 12'o6046, 12'h0b1, 1'b0, 12'h0b1, 1'b0, 8'h00, 1'b1);
    probe("tx_b1_pending", 4'b0101, 8'hb1);
    a.tx_ready = 1'b1;
    iot(0, "tls_b2_simul", 12'o6046, 12'h0b2, 1'b0, 12'h0b2, 1'b0, 8'h00, 1'b1);
    a.tx_ready = 1'b0;
    probe("tx_simul_flag_wins", 4'b0111, 8'hb2);
    tx_pulse(1);
    probe("tx_simul_drained", 4'b0110, 8'h00);

    // reset mid-transfer wins over IOT, rx strobe and handshake
    iot(0, "tls_c1", 12'o6046, 12'h0c1, 1'b0, 12'h0c1);
    probe("tx_c1_pending", 4'b0101, 8'hc1);
    reset = 1'b1;
    a.tx_ready = 1'b1;
    iot(0, "tls_d1_in_reset", 12'o6046, 12'h0d1, 1'b0, 12'h0d1, 1'b1, 8'h77);
    reset = 1'b0;
    a.tx_ready = 1'b0;
    probe("after_mid_reset", 4'b0000, 8'h00);
    iot(0, "ksf_after_reset", 12'o6031, 12'o0000, 1'b0, 12'o0000);

    // MARK8 unit
    rx(1, 8'o101);
    iot(1, "mark8_krb", 12'o6036, 12'o0000, 1'b0, 12'o0301);
    iot(1, "mark8_empty", 12'o6036, 12'o0000, 1'b0, 12'o0200);
    iot(1, "mark8_ksf", 12'o6031, 12'o0000, 1'b0, 12'o0000);

    repeat (3) step();
    check("iot_a_leftover", 32'(iota_q.size()), 32'd0);
    check("iot_b_leftover", 32'(iotb_q.size()), 32'd0);
    check("tx_leftover", 32'(tx_q.size()), 32'd0);
    check("probe_leftover", 32'(st_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
